// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with a 2-entry skid buffer and valid/ready handshake.
// Define EXMEM_FWD_EN to add the ID-stage forwarding lookup ports.
module ex_mem_skid #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          exmem_i_flush,
    input  logic          exmem_i_valid,
    output logic          exmem_o_ready,
    input  logic          exmem_i_wreg,
    input  logic [AW-1:0] exmem_i_waddr,
    input  logic [DW-1:0] exmem_i_wdata,
    output logic          exmem_o_valid,
    input  logic          exmem_i_ready,
    output logic          exmem_o_wreg,
    output logic [AW-1:0] exmem_o_waddr,
    output logic [DW-1:0] exmem_o_wdata
`ifdef EXMEM_FWD_EN
    ,
    input  logic [AW-1:0] fwd_i_raddr0,
    input  logic [AW-1:0] fwd_i_raddr1,
    output logic          fwd_o_hit0,
    output logic          fwd_o_hit1,
    output logic [DW-1:0] fwd_o_data0,
    output logic [DW-1:0] fwd_o_data1
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          main_wreg_q, main_wreg_d;
    logic [AW-1:0] main_waddr_q, main_waddr_d;
    logic [DW-1:0] main_wdata_q, main_wdata_d;
    logic          skid_wreg_q, skid_wreg_d;
    logic [AW-1:0] skid_waddr_q, skid_waddr_d;
    logic [DW-1:0] skid_wdata_q, skid_wdata_d;

    logic push, pop;

    assign exmem_o_ready = (state_q != ST_TWO);
    assign exmem_o_valid = (state_q != ST_EMPTY);
    assign push          = exmem_i_valid & exmem_o_ready;
    assign pop           = exmem_o_valid & exmem_i_ready;

    // main_wreg_q is cleared whenever the buffer goes empty, so o_wreg can be
    // driven straight from the register without gating by valid.
    assign exmem_o_wreg  = main_wreg_q;
    assign exmem_o_waddr = main_waddr_q;
    assign exmem_o_wdata = main_wdata_q;

    always_comb begin
        // NOTE: every variable gets a hold-value default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        main_wreg_d  = main_wreg_q;
        main_waddr_d = main_waddr_q;
        main_wdata_d = main_wdata_q;
        skid_wreg_d  = skid_wreg_q;
        skid_waddr_d = skid_waddr_q;
        skid_wdata_d = skid_wdata_q;

        if (exmem_i_flush) begin
            state_d     = ST_EMPTY;
            main_wreg_d = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_wreg_d  = exmem_i_wreg;
                        main_waddr_d = exmem_i_waddr;
                        main_wdata_d = exmem_i_wdata;
                        state_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        skid_wreg_d  = exmem_i_wreg;
                        skid_waddr_d = exmem_i_waddr;
                        skid_wdata_d = exmem_i_wdata;
                        state_d      = ST_TWO;
                    end else if (push && pop) begin
                        main_wreg_d  = exmem_i_wreg;
                        main_waddr_d = exmem_i_waddr;
                        main_wdata_d = exmem_i_wdata;
                    end else if (pop) begin
                        main_wreg_d = 1'b0;
                        state_d     = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_wreg_d  = skid_wreg_q;
                        main_waddr_d = skid_waddr_q;
                        main_wdata_d = skid_wdata_q;
                        state_d      = ST_ONE;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_wreg_d = 1'b0;
                end
            endcase
        end
    end

    // NOTE: both entries are plain flops, not a memory array, so all of them are
    // reset; that keeps the held waddr/wdata outputs defined out of reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= ST_EMPTY;
            main_wreg_q  <= 1'b0;
            main_waddr_q <= '0;
            main_wdata_q <= '0;
            skid_wreg_q  <= 1'b0;
            skid_waddr_q <= '0;
            skid_wdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register.
            state_q      <= state_d;
            main_wreg_q  <= main_wreg_d;
            main_waddr_q <= main_waddr_d;
            main_wdata_q <= main_wdata_d;
            skid_wreg_q  <= skid_wreg_d;
            skid_waddr_q <= skid_waddr_d;
            skid_wdata_q <= skid_wdata_d;
        end
    end

`ifdef EXMEM_FWD_EN
    function automatic logic fwd_match(input logic v, input logic w,
                                       input logic [AW-1:0] a, input logic [AW-1:0] r);
        return v & w & (r != '0) & (a == r);
    endfunction

    logic main_hit0, main_hit1, skid_hit0, skid_hit1;

    assign main_hit0 = fwd_match(exmem_o_valid, main_wreg_q, main_waddr_q, fwd_i_raddr0);
    assign main_hit1 = fwd_match(exmem_o_valid, main_wreg_q, main_waddr_q, fwd_i_raddr1);
    assign skid_hit0 = fwd_match(state_q == ST_TWO, skid_wreg_q, skid_waddr_q, fwd_i_raddr0);
    assign skid_hit1 = fwd_match(state_q == ST_TWO, skid_wreg_q, skid_waddr_q, fwd_i_raddr1);

    // SKID is the younger entry, so it wins when both match.
    assign fwd_o_hit0  = main_hit0 | skid_hit0;
    assign fwd_o_hit1  = main_hit1 | skid_hit1;
    assign fwd_o_data0 = skid_hit0 ? skid_wdata_q : (main_hit0 ? main_wdata_q : '0);
    assign fwd_o_data1 = skid_hit1 ? skid_wdata_q : (main_hit1 ? main_wdata_q : '0);
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: expected entries queued by the driver,
// compared by an independent monitor against a 2-deep FIFO reference.
module tb_ex_mem_skid;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic          wreg;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_ = 1'b0;
    logic          exmem_i_flush = 1'b0;
    logic          exmem_i_valid = 1'b0;
    logic          exmem_o_ready;
    logic          exmem_i_wreg = 1'b0;
    logic [AW-1:0] exmem_i_waddr = '0;
    logic [DW-1:0] exmem_i_wdata = '0;
    logic          exmem_o_valid;
    logic          exmem_i_ready = 1'b0;
    logic          exmem_o_wreg;
    logic [AW-1:0] exmem_o_waddr;
    logic [DW-1:0] exmem_o_wdata;
`ifdef EXMEM_FWD_EN
    logic [AW-1:0] fwd_i_raddr0 = '0;
    logic [AW-1:0] fwd_i_raddr1 = '0;
    logic          fwd_o_hit0, fwd_o_hit1;
    logic [DW-1:0] fwd_o_data0, fwd_o_data1;
`endif

    ex_mem_skid #(.DW(DW), .AW(AW)) dut (
        .clk           (clk),
        .rst_          (rst_),
        .exmem_i_flush (exmem_i_flush),
        .exmem_i_valid (exmem_i_valid),
        .exmem_o_ready (exmem_o_ready),
        .exmem_i_wreg  (exmem_i_wreg),
        .exmem_i_waddr (exmem_i_waddr),
        .exmem_i_wdata (exmem_i_wdata),
        .exmem_o_valid (exmem_o_valid),
        .exmem_i_ready (exmem_i_ready),
        .exmem_o_wreg  (exmem_o_wreg),
        .exmem_o_waddr (exmem_o_waddr),
        .exmem_o_wdata (exmem_o_wdata)
`ifdef EXMEM_FWD_EN
        ,
        .fwd_i_raddr0  (fwd_i_raddr0),
        .fwd_i_raddr1  (fwd_i_raddr1),
        .fwd_o_hit0    (fwd_o_hit0),
        .fwd_o_hit1    (fwd_o_hit1),
        .fwd_o_data0   (fwd_o_data0),
        .fwd_o_data1   (fwd_o_data1)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    ent_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the model is an ordered queue of at most two accepted entries.
    always @(negedge clk) begin
        if (mon_en && rst_) begin
            check("o_valid", 32'(exmem_o_valid), 32'(sbq.size() > 0));
            check("o_ready", 32'(exmem_o_ready), 32'(sbq.size() < 2));
            if (sbq.size() > 0) begin
                check("o_wreg",  32'(exmem_o_wreg),  32'(sbq[0].wreg));
                check("o_waddr", 32'(exmem_o_waddr), 32'(sbq[0].waddr));
                check("o_wdata", 32'(exmem_o_wdata), 32'(sbq[0].wdata));
            end else begin
                check("idle_wreg", 32'(exmem_o_wreg), 32'd0);
            end
`ifdef EXMEM_FWD_EN
            begin
                logic          h0, h1;
                logic [DW-1:0] d0, d1;
                h0 = 1'b0; h1 = 1'b0; d0 = '0; d1 = '0;
                for (int i = 0; i < sbq.size(); i++) begin
                    if (sbq[i].wreg && fwd_i_raddr0 != 0 && sbq[i].waddr == fwd_i_raddr0) begin
                        h0 = 1'b1; d0 = sbq[i].wdata;
                    end
                    if (sbq[i].wreg && fwd_i_raddr1 != 0 && sbq[i].waddr == fwd_i_raddr1) begin
                        h1 = 1'b1; d1 = sbq[i].wdata;
                    end
                end
                check("fwd_hit0",  32'(fwd_o_hit0),  32'(h0));
                check("fwd_data0", 32'(fwd_o_data0), 32'(d0));
                check("fwd_hit1",  32'(fwd_o_hit1),  32'(h1));
                check("fwd_data1", 32'(fwd_o_data1), 32'(d1));
            end
`endif
            if (exmem_i_flush) sbq.delete();
            else if (exmem_o_valid && exmem_i_ready && sbq.size() > 0) void'(sbq.pop_front());
        end
    end

    // One clock cycle: drive at posedge+1, record acceptance after the monitor
    // has run, return at the next posedge+1 with the new state visible.
    task automatic cyc(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rdy, input logic fl);
        ent_t e;
        exmem_i_valid = v;
        exmem_i_wreg  = w;
        exmem_i_waddr = a;
        exmem_i_wdata = d;
        exmem_i_ready = rdy;
        exmem_i_flush = fl;
        @(negedge clk);
        #1;
        if (v && exmem_o_ready && !fl) begin
            e.wreg = w; e.waddr = a; e.wdata = d;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, '0, '0, rdy, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", 32'(exmem_o_valid), 32'd0);
        check("rst_ready", 32'(exmem_o_ready), 32'd1);
        check("rst_wreg",  32'(exmem_o_wreg),  32'd0);
        check("rst_waddr", 32'(exmem_o_waddr), 32'd0);
        check("rst_wdata", 32'(exmem_o_wdata), 32'd0);
        mon_en = 1'b1;

        // Single transfer, one-cycle latency.
        cyc(1'b1, 1'b1, 5'd3, 32'h1234_5678, 1'b1, 1'b0);
        check("single_valid", 32'(exmem_o_valid), 32'd1);
        check("single_wdata", exmem_o_wdata, 32'h1234_5678);
        check("single_waddr", 32'(exmem_o_waddr), 32'd3);
        idle(1'b1);
        check("single_empty", 32'(exmem_o_valid), 32'd0);

        // Back-pressure fills both entries, then drains in order.
        cyc(1'b1, 1'b1, 5'd1, 32'hA, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 5'd2, 32'hB, 1'b0, 1'b0);
        check("bp_ready", 32'(exmem_o_ready), 32'd0);
        check("bp_hold_a", exmem_o_wdata, 32'hA);
        cyc(1'b1, 1'b1, 5'd9, 32'hBAD, 1'b0, 1'b0);
        check("bp_still_a", exmem_o_wdata, 32'hA);
        idle(1'b1);
        check("bp_then_b", exmem_o_wdata, 32'hB);
        idle(1'b1);
        check("bp_empty", 32'(exmem_o_valid), 32'd0);

        // Simultaneous push and pop in ONE.
        cyc(1'b1, 1'b1, 5'd4, 32'hA1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 5'd6, 32'hC, 1'b1, 1'b0);
        check("pp_c", exmem_o_wdata, 32'hC);
        check("pp_ready", 32'(exmem_o_ready), 32'd1);
        idle(1'b1);

        // Flush from TWO with a concurrent push.
        cyc(1'b1, 1'b1, 5'd8, 32'h51, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 5'd9, 32'h52, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 5'd10, 32'hD, 1'b0, 1'b1);
        check("fl_valid", 32'(exmem_o_valid), 32'd0);
        check("fl_ready", 32'(exmem_o_ready), 32'd1);
        check("fl_wreg",  32'(exmem_o_wreg),  32'd0);
        idle(1'b1);
        idle(1'b1);

        // wreg=1 to r0 passes through unchanged.
        cyc(1'b1, 1'b1, 5'd0, 32'hFEED, 1'b1, 1'b0);
        check("r0_wreg", 32'(exmem_o_wreg), 32'd1);
        idle(1'b1);

`ifdef EXMEM_FWD_EN
        cyc(1'b1, 1'b1, 5'd7, 32'h11, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 5'd7, 32'h22, 1'b0, 1'b0);
        fwd_i_raddr0 = 5'd7;
        fwd_i_raddr1 = 5'd0;
        #1;
        check("fwd_dir_hit0",  32'(fwd_o_hit0), 32'd1);
        check("fwd_dir_data0", fwd_o_data0, 32'h22);
        check("fwd_dir_hit1",  32'(fwd_o_hit1), 32'd0);
        idle(1'b1);
        idle(1'b1);
`endif

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 600; n++) begin
`ifdef EXMEM_FWD_EN
            fwd_i_raddr0 = AW'($urandom_range(0, 7));
            fwd_i_raddr1 = AW'($urandom_range(0, 7));
`endif
            cyc($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 7)),
                $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end

        // Asynchronous reset with data in flight.
        cyc(1'b1, 1'b1, 5'd5, 32'h77, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 5'd5, 32'h78, 1'b0, 1'b0);
        exmem_i_valid = 1'b0;
        mon_en = 1'b0;
        #2;
        rst_ = 1'b0;
        #1;
        check("arst_valid", 32'(exmem_o_valid), 32'd0);
        check("arst_ready", 32'(exmem_o_ready), 32'd1);
        check("arst_wreg",  32'(exmem_o_wreg),  32'd0);
        sbq.delete();
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(1'b1, 1'b1, 5'd12, 32'hCAFE, 1'b0, 1'b0);
        check("post_rst_data", exmem_o_wdata, 32'hCAFE);

        // Bounded drain of whatever remains.
        for (int n = 0; n < 8 && sbq.size() > 0; n++) idle(1'b1);
        check("drain_empty", 32'(sbq.size()), 32'd0);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
